divu_unit: RTL and testbench

Sequential 32-bit unsigned divider. Executes the DIVU function code broadcast by the ALU control stage on its divider-control bus and produces a 64-bit {remainder, quotient} word for the HiLo register. Computes one quotient bit per clock (restoring division). Holds the result stable until the HiLo write strobe has been issued and the control code moves on.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/divu_unit_div_step.sv | 30 +++
 rtl/divu_unit.sv | 105 ++++++++++
 tb/tb_divu_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, ALU-control function codes and the
// divider state encoding used by divu_unit.
package alu_pkg;

   localparam int WIDTH = 32;

   localparam logic [5:0] FN_AND       = 6'b100100;
   localparam logic [5:0] FN_OR        = 6'b100101;
   localparam logic [5:0] FN_ADD       = 6'b100000;
   localparam logic [5:0] FN_SUB       = 6'b100010;
   localparam logic [5:0] FN_SLT       = 6'b101010;
   localparam logic [5:0] FN_SRL       = 6'b000010;
   localparam logic [5:0] FN_MULTU     = 6'b011001;
   localparam logic [5:0] FN_DIVU      = 6'b011011;
   localparam logic [5:0] FN_MFHI      = 6'b010000;
   localparam logic [5:0] FN_MFLO      = 6'b010010;
   localparam logic [5:0] FN_HILO_OPEN = 6'b111111;

   localparam logic [1:0] DIVU_IDLE = 2'd0;
   localparam logic [1:0] DIVU_RUN  = 2'd1;
   localparam logic [1:0] DIVU_DONE = 2'd2;

endpackage

// File: rtl/divu_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
   import alu_pkg::*;
(
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   assign shifted = {rem_i[WIDTH-1:0], q_i[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor_i};

   // A clear borrow bit means the divisor fit, so keep the difference.
   always_comb begin
      if (!trial[WIDTH]) begin
         rem_o = trial;
         q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted;
         q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/divu_unit.sv
// Sequential 32-bit unsigned divider producing {remainder, quotient} for HiLo,
// one quotient bit per clock, holding the result until the control code moves on.
module divu_unit
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [5:0]           Signal,
   input  logic [WIDTH-1:0]     dataA,
   input  logic [WIDTH-1:0]     dataB,
   output logic [2*WIDTH-1:0]   dataOut,
   output logic                 busy,
   output logic                 done,
   output logic                 divByZero
);

   logic [1:0]         state_q, state_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic [4:0]         count_q, count_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               dbz_q, dbz_d;

   logic [WIDTH:0]     stepRem;
   logic [WIDTH-1:0]   stepQuo;
   logic               keepGoing;

   div_step u_step (
      .rem_i     (rem_q),
      .q_i       (quo_q),
      .divisor_i (divisor_q),
      .rem_o     (stepRem),
      .q_o       (stepQuo)
   );

   assign keepGoing = (Signal == FN_DIVU) || (Signal == FN_HILO_OPEN);

   // Abort is checked before iterating, so an aborted run never touches the
   // held result; only the 32nd iteration publishes dataOut and divByZero.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      count_d   = count_q;
      result_d  = result_q;
      dbz_d     = dbz_q;
      case (state_q)
         DIVU_IDLE: begin
            if (Signal == FN_DIVU) begin
               state_d   = DIVU_RUN;
               rem_d     = '0;
               quo_d     = dataA;
               divisor_d = dataB;
               count_d   = '0;
            end
         end
         DIVU_RUN: begin
            if (!keepGoing) begin
               state_d = DIVU_IDLE;
            end else begin
               rem_d   = stepRem;
               quo_d   = stepQuo;
               count_d = count_q + 5'd1;
               if (count_q == 5'd31) begin
                  state_d  = DIVU_DONE;
                  result_d = {stepRem[WIDTH-1:0], stepQuo};
                  dbz_d    = (divisor_q == '0);
               end
            end
         end
         DIVU_DONE: begin
            if (!keepGoing) state_d = DIVU_IDLE;
         end
         default: state_d = DIVU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DIVU_IDLE;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         count_q   <= '0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         count_q   <= count_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
      end
   end

   assign dataOut   = result_q;
   assign divByZero = dbz_q;
   assign busy      = (state_q == DIVU_RUN);
   assign done      = (state_q == DIVU_DONE);

endmodule

// File: tb/tb_divu_unit.sv
// Scoreboard bench for divu_unit: stimulus pushes expected {rem, quo} results,
// a monitor pops and compares them whenever done rises.
module tb_divu_unit;
   import alu_pkg::*;

   typedef struct {
      logic [63:0] data;
      logic        dbz;
      int          doneAt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  Signal = FN_ADD;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic [63:0] dataOut;
   logic        busy, done, divByZero;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   doneRises = 0;
   logic prevDone = 1'b0;
   exp_t expQ[$];

   divu_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Signal    (Signal),
      .dataA     (dataA),
      .dataB     (dataB),
      .dataOut   (dataOut),
      .busy      (busy),
      .done      (done),
      .divByZero (divByZero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer division; a zero divisor gives all-ones
   // quotient and the dividend as remainder.
   function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done rising edge must match the oldest outstanding result.
   always @(negedge clk) begin
      if (busy && done) checkOutput("busy_done_exclusive", 64'd1, 64'd0);
      if (done && !prevDone) begin
         doneRises++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("dataOut", dataOut, e.data);
            checkOutput("divByZero", {63'd0, divByZero}, {63'd0, e.dbz});
            checkOutput("latency", 64'(cyc), 64'(e.doneAt));
         end
      end
      prevDone = done;
   end

   // Drives a start request at a negedge; the following rising edge is E0.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit expectDone);
      exp_t e;
      @(negedge clk);
      Signal = FN_DIVU;
      dataA  = a;
      dataB  = b;
      if (expectDone) begin
         e.data   = refDiv(a, b);
         e.dbz    = (b == 32'd0);
         e.doneAt = cyc + 33;
         expQ.push_back(e);
      end
      @(negedge clk);
      dataA = $urandom;
      dataB = $urandom;
      checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
   endtask

   task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input int hiloAt);
      bit finished = 1'b0;
      applyStimulus(a, b, 1'b1);
      for (int i = 2; i <= 40 && !finished; i++) begin
         @(negedge clk);
         if (i == hiloAt) Signal = FN_HILO_OPEN;
         if (done) finished = 1'b1;
      end
      checkOutput("done_within_budget", {63'd0, finished}, 64'd1);
      @(negedge clk);
      Signal = FN_HILO_OPEN;
      @(negedge clk);
      checkOutput("done_held_hilo", {63'd0, done}, {63'd0, finished});
      Signal = FN_MFLO;
      @(negedge clk);
      checkOutput("done_cleared", {63'd0, done}, 64'd0);
      checkOutput("dataOut_kept_idle", dataOut, refDiv(a, b));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int r0;
      #1;
      checkOutput("reset_dataOut", dataOut, 64'd0);
      checkOutput("reset_flags", {61'd0, busy, done, divByZero}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      runDiv(32'd100, 32'd7, -1);
      checkOutput("100_div_7_literal", dataOut, {32'd2, 32'd14});
      runDiv(32'hFFFF_FFFF, 32'd1, -1);
      runDiv(32'd5, 32'd0, -1);
      runDiv(32'd100, 32'd7, 31);

      // Abort a 9/10 division after ten RUN cycles with an unrelated code.
      r0 = doneRises;
      applyStimulus(32'd9, 32'd10, 1'b0);
      repeat (9) @(negedge clk);
      checkOutput("busy_before_abort", {63'd0, busy}, 64'd1);
      Signal = FN_ADD;
      @(negedge clk);
      checkOutput("abort_flags", {62'd0, busy, done}, 64'd0);
      repeat (40) @(negedge clk);
      checkOutput("abort_no_done", 64'(doneRises), 64'(r0));
      checkOutput("abort_dataOut_kept", dataOut, refDiv(32'd100, 32'd7));

      // Reset in the middle of a run discards everything immediately.
      applyStimulus(32'd123456, 32'd77, 1'b0);
      repeat (13) @(negedge clk);
      checkOutput("busy_before_reset", {63'd0, busy}, 64'd1);
      rst_n  = 1'b0;
      Signal = FN_ADD;
      #1;
      checkOutput("midrun_reset_dataOut", dataOut, 64'd0);
      checkOutput("midrun_reset_flags", {61'd0, busy, done, divByZero}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      runDiv(32'd100, 32'd7, -1);

      // Holding DIVU well past completion must not restart a division.
      r0 = doneRises;
      applyStimulus(32'd1000, 32'd33, 1'b1);
      repeat (50) @(negedge clk);
      checkOutput("single_division", 64'(doneRises), 64'(r0 + 1));
      checkOutput("held_done", {63'd0, done}, 64'd1);
      Signal = FN_MFLO;
      @(negedge clk);

      for (int n = 0; n < 10; n++) begin
         logic [31:0] a, b;
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = a + 32'd1;
            default: b = $urandom;
         endcase
         runDiv(a, b, ($urandom_range(0, 1) == 1) ? 33 : -1);
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
